// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier among NREQ requesters: round-robin grant, S1 operand
// register, S2 product register. Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 slow_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_result,
  output logic                 busy,
  output logic [31:0]          op_count
);

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // the response side has no backpressure and rsp_valid pulses for exactly one cycle.

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [IDW-1:0]  cand;

  logic            s1_v_q;
  logic [31:0]     s1_a_q, s1_b_q;
  logic [IDW-1:0]  s1_id_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [63:0]     rsp_result_q;
  logic [31:0]     op_count_q;

`ifndef MULT_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  ptr_q, ptr_d;
`endif

  // First valid requester in search order wins; the order starts at ptr (or at 0 when fixed).
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      cand = IDW'(k);
`else
      cand = IDW'((int'(ptr_q) + k) % NREQ);
`endif
      if (!gnt_any && req_valid[cand]) begin
        gnt_any   = 1'b1;
        gnt_id    = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

`ifndef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = IDW'((int'(gnt_id) + 1) % NREQ);
  end

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign req_ready = rst ? '0 : gnt;

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      op_count_q   <= '0;
    end else begin
      s1_v_q <= gnt_any;
      if (gnt_any) begin
        s1_a_q  <= req_a[32*gnt_id +: 32];
        s1_b_q  <= req_b[32*gnt_id +: 32];
        s1_id_q <= gnt_id;
      end
      // Full 64-bit product; operands are widened so nothing truncates.
      rsp_result_q <= 64'(s1_a_q) * 64'(s1_b_q);
      rsp_id_q     <= s1_id_q;
      rsp_valid_q  <= s1_v_q;
      if (rsp_valid_q) op_count_q <= op_count_q + 32'd1;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign op_count   = op_count_q;
  assign busy       = s1_v_q | rsp_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, hand sequences and random traffic
// checked against a queue-based reference model.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 32 + IDW + 64;

  logic               slow_clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_result;
  logic               busy;
  logic [31:0]        op_count;

  mult_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .slow_clk(slow_clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .op_count(op_count)
  );

  // clock / reset
  initial begin
    slow_clk = 1'b0;
    forever #5 slow_clk = ~slow_clk;
  end

  // scoreboard: {due cycle, id, product}
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last     = NREQ - 1;
  logic [31:0]  exp_ops  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: the search starts just after the last granted requester.
  function automatic int model_winner();
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (req_valid[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (req_valid[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  // driver: one clock cycle, entered and left just after a falling edge
  task automatic cycle(output int w);
    logic [NREQ-1:0] exp_rdy;
    logic [W-1:0]    item;
    logic            popped;
    logic [63:0]     prod;
    #1;
    w = model_winner();
    exp_rdy = (w < 0) ? '0 : NREQ'(1 << w);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (w >= 0) begin
      prod = 64'(req_a[32*w +: 32]) * 64'(req_b[32*w +: 32]);
      exp_q.push_back({32'(cyc + 2), IDW'(w), prod});
      last = w;
    end
    @(posedge slow_clk);
    cyc++;
    @(negedge slow_clk);
    popped = 1'b0;
    chk("op_count", 64'(op_count), 64'(exp_ops));
    if (exp_q.size() != 0 && exp_q[0][W-1:W-32] == 32'(cyc)) begin
      item   = exp_q.pop_front();
      popped = 1'b1;
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(item[63+IDW:64]));
      chk("rsp_result", rsp_result, item[63:0]);
      exp_ops++;
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    chk("busy", 64'(busy), 64'(popped || exp_q.size() != 0));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    @(negedge slow_clk);
    rst       = 1'b0;
    req_valid = '0;
    exp_q.delete();
    last    = NREQ - 1;
    exp_ops = '0;
  endtask

  task automatic idle(input int n);
    int w;
    req_valid = '0;
    for (int i = 0; i < n; i++) cycle(w);
  endtask

  typedef struct {
    logic [NREQ-1:0]    valid;
    logic [32*NREQ-1:0] a;
    logic [32*NREQ-1:0] b;
    logic [NREQ-1:0]    rdy_rr;
    logic [NREQ-1:0]    rdy_fp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int w;
    logic [NREQ-1:0] exp_g;
    logic [NREQ-1:0] pend;

    tbl[0] = '{4'b0100, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd5, 32'd6, 32'd7}, 4'b0100, 4'b0100};
    tbl[1] = '{4'b0000, {32'd0, 32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000, 4'b0000};
    tbl[2] = '{4'b1111, {32'hFFFFFFFF, 32'd10, 32'd11, 32'hFFFFFFFF}, {32'hFFFFFFFF, 32'd3, 32'd4, 32'hFFFFFFFF}, 4'b1000, 4'b0001};
    tbl[3] = '{4'b1111, {32'd9, 32'd8, 32'd7, 32'd0}, {32'd1, 32'd2, 32'd3, 32'hDEADBEEF}, 4'b0001, 4'b0001};
    tbl[4] = '{4'b1111, {32'd5, 32'd6, 32'h12345678, 32'd1}, {32'd5, 32'd6, 32'h9ABCDEF0, 32'd1}, 4'b0010, 4'b0001};
    tbl[5] = '{4'b0101, {32'd0, 32'd100, 32'd0, 32'd200}, {32'd0, 32'd7, 32'd0, 32'd9}, 4'b0100, 4'b0001};
    tbl[6] = '{4'b0001, {32'd0, 32'd0, 32'd0, 32'h80000000}, {32'd0, 32'd0, 32'd0, 32'd2}, 4'b0001, 4'b0001};
    tbl[7] = '{4'b1010, {32'd77, 32'd0, 32'd55, 32'd0}, {32'd3, 32'd0, 32'd11, 32'd0}, 4'b0010, 4'b0010};
    tbl[8] = '{4'b1000, {32'hFFFF0000, 32'd0, 32'd0, 32'd0}, {32'h0000FFFF, 32'd0, 32'd0, 32'd0}, 4'b1000, 4'b1000};
    tbl[9] = '{4'b0110, {32'd0, 32'd13, 32'd17, 32'd0}, {32'd0, 32'd19, 32'd23, 32'd0}, 4'b0010, 4'b0010};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    do_reset();

    // table-driven vectors
    foreach (tbl[i]) begin
      req_valid = tbl[i].valid; req_a = tbl[i].a; req_b = tbl[i].b;
      #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
      chk("tbl_grant", 64'(req_ready), 64'(tbl[i].rdy_fp));
`else
      chk("tbl_grant", 64'(req_ready), 64'(tbl[i].rdy_rr));
`endif
      cycle(w);
    end
    idle(2);

    // single request from requester 2
    do_reset();
    req_valid = 4'b0100; req_a = '0; req_b = '0;
    req_a[64 +: 32] = 32'd3; req_b[64 +: 32] = 32'd5;
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    cycle(w);
    req_valid = '0;
    chk("single_e1_valid", 64'(rsp_valid), 64'd0);
    chk("single_e1_busy", 64'(busy), 64'd1);
    cycle(w);
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_result", rsp_result, 64'd15);
    cycle(w);
    chk("single_pulse_end", 64'(rsp_valid), 64'd0);
    chk("single_op_count", 64'(op_count), 64'd1);
    chk("single_busy_end", 64'(busy), 64'd0);

    // saturation
    do_reset();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = $urandom();
      req_b[32*i +: 32] = $urandom();
    end
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = NREQ'(1 << (k % NREQ));
`endif
      chk("sat_grant", 64'(req_ready), 64'(exp_g));
      cycle(w);
    end
    idle(2);
    chk("sat_op_count", 64'(op_count), 64'd8);

    // width corner cases, back to back on requester 0
    req_valid = 4'b0001;
    req_a[31:0] = 32'hFFFFFFFF; req_b[31:0] = 32'hFFFFFFFF;
    cycle(w);
    req_a[31:0] = 32'h0; req_b[31:0] = 32'hDEADBEEF;
    cycle(w);
    req_valid = '0;
    chk("max_product", rsp_result, 64'hFFFFFFFE00000001);
    cycle(w);
    chk("zero_product", rsp_result, 64'd0);
    chk("zero_product_valid", 64'(rsp_valid), 64'd1);
    idle(1);

    // reset the cycle after a transfer
    req_valid = 4'b0001; req_a[31:0] = 32'd6; req_b[31:0] = 32'd7;
    cycle(w);
    do_reset();
    idle(3);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    req_valid = 4'b1010;
    #1 chk("midrst_first_grant", 64'(req_ready), 64'b0010);
    cycle(w);
    idle(2);

    // sparse: requester 3 then requester 1, no wait for the pointer to wrap
    do_reset();
    req_valid = 4'b1000;
    cycle(w);
    req_valid = 4'b0010;
    #1 chk("sparse_grant1", 64'(req_ready), 64'b0010);
    cycle(w);
    req_valid = '0;
    cycle(w);
    chk("sparse_busy_e1", 64'(busy), 64'd1);
    cycle(w);
    chk("sparse_busy_e2", 64'(busy), 64'd0);

    // random traffic: requesters hold operands until granted
    do_reset();
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          case ($urandom_range(0, 3))
            0:       req_a[32*i +: 32] = 32'h0;
            1:       req_a[32*i +: 32] = 32'hFFFFFFFF;
            default: req_a[32*i +: 32] = $urandom();
          endcase
          req_b[32*i +: 32] = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom();
        end
      end
      req_valid = pend;
      cycle(w);
      if (w >= 0) pend[w] = 1'b0;
    end
    idle(3);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
